// File: rtl/fetch_unit.sv
// fetch_unit
//   Instruction fetch stage feeding the control decoder. Owns the program
//   counter and drives the instruction-memory address. It registers the
//   fetched instruction, resolves taken BLQZ branches with a one-cycle bubble,
//   honours stalls, and reports program completion via a start/done handshake.
//
// Ports
//   clk            system clock, rising edge
//   reset_n        asynchronous active-low reset
//   start          one-cycle pulse, begins execution at address 0 (IDLE/DONE only)
//   prog_len       address one past the last instruction, sampled every cycle
//   imem_addr      instruction-memory address (copy of the pc register)
//   imem_rdata     instruction-memory read data, combinational from imem_addr
//   instr          registered instruction presented to the decoder
//   instr_valid    instr is live and not squashed
//   stall          hold pc, instr, instr_valid and state
//   branch_taken   datapath condition for the BLQZ currently in instr
//   branch_target  target address of the taken branch
//   done           program finished, level until the next start
//   retired_cnt    saturating count of delivered instructions
//
// Configuration
//   FETCH_PERF_CNT_EN  when defined, builds the retired-instruction counter;
//                      otherwise retired_cnt is tied to zero.

module fetch_unit #(
  parameter int unsigned PC_W    = 10,
  parameter int unsigned IW      = 9,
  parameter logic [2:0]  BLQZ_OP = 3'b111
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic [PC_W-1:0] prog_len,
  output logic [PC_W-1:0] imem_addr,
  input  logic [IW-1:0]   imem_rdata,
  output logic [IW-1:0]   instr,
  output logic            instr_valid,
  input  logic            stall,
  input  logic            branch_taken,
  input  logic [PC_W-1:0] branch_target,
  output logic            done,
  output logic [15:0]     retired_cnt
);

  localparam int unsigned OPC_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [IW-1:0]   instr_q, instr_d;
  logic            valid_q, valid_d;
  logic            done_q, done_d;

  logic [OPC_W-1:0] opcode;
  logic             branch_go;
  logic             at_end;

  // Decoder-side view of the instruction currently held in instr.
  assign opcode    = instr_q[IW-1 -: OPC_W];
  assign branch_go = valid_q && (opcode == BLQZ_OP) && branch_taken;
  assign at_end    = (pc_q == prog_len);

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      pc_q    <= '0;
      instr_q <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  // Next-state and next-datapath logic; everything holds unless told otherwise.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    done_d  = done_q;

    case (state_q)
      IDLE: begin
        valid_d = 1'b0;
        pc_d    = '0;
        if (start) begin
          state_d = RUN;
        end
      end

      RUN: begin
        if (!stall) begin
          if (branch_go) begin
            // Redirect and squash the wrong-path fetch; wins over end detection.
            pc_d    = branch_target;
            valid_d = 1'b0;
          end else if (at_end) begin
            // No fetch at prog_len; the last instruction leaves instr here.
            valid_d = 1'b0;
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            instr_d = imem_rdata;
            valid_d = 1'b1;
            pc_d    = pc_q + PC_W'(1);
          end
        end
      end

      DONE: begin
        valid_d = 1'b0;
        if (start) begin
          done_d  = 1'b0;
          pc_d    = '0;
          state_d = RUN;
        end
      end

      default: begin
        state_d = IDLE;
        pc_d    = '0;
        valid_d = 1'b0;
        done_d  = 1'b0;
      end
    endcase
  end

  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign instr_valid = valid_q;
  assign done        = done_q;

`ifdef FETCH_PERF_CNT_EN
  localparam int unsigned CNT_W = 16;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             start_accept;

  // start is only honoured outside RUN, so only then does it clear the count.
  assign start_accept = start && (state_q != RUN);

  // Saturating count of instructions consumed by the decoder.
  always_comb begin
    cnt_d = cnt_q;
    if (start_accept) begin
      cnt_d = '0;
    end else if (valid_q && !stall && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign retired_cnt = cnt_q;
`else
  assign retired_cnt = '0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a behavioural model tracks the expected
// program flow (pc, delivered instructions, done, retire count) and is compared
// against the DUT on every falling edge; literal checks pin the model.

module tb_fetch_unit;

  localparam int unsigned PC_W = 10;
  localparam int unsigned IW   = 9;
  localparam int unsigned MEMN = 1024;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            start;
  logic [PC_W-1:0] prog_len;
  logic [PC_W-1:0] imem_addr;
  logic [IW-1:0]   imem_rdata;
  logic [IW-1:0]   instr;
  logic            instr_valid;
  logic            stall;
  logic            branch_taken;
  logic [PC_W-1:0] branch_target;
  logic            done;
  logic [15:0]     retired_cnt;

  logic [IW-1:0] mem [0:MEMN-1];

  int n_chk  = 0;
  int n_fail = 0;

  assign imem_rdata = mem[imem_addr];

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .start         (start),
    .prog_len      (prog_len),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .instr         (instr),
    .instr_valid   (instr_valid),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .done          (done),
    .retired_cnt   (retired_cnt)
  );

  // ---------------- behavioural model ----------------
  int       m_pc      = 0;
  bit       m_running = 1'b0;
  bit       m_done    = 1'b0;
  bit       m_valid   = 1'b0;
  logic [8:0] m_instr = '0;
  int       m_addr    = 0;
  int       m_cnt     = 0;
  int       m_log[$];

  task automatic model_reset();
    m_pc = 0; m_running = 1'b0; m_done = 1'b0; m_valid = 1'b0;
    m_instr = '0; m_addr = 0; m_cnt = 0;
  endtask

  // One clock of program flow, from the rules: decode consumes, then fetch.
  task automatic model_step();
    bit is_branch;
    is_branch = m_valid && (m_instr[8:6] == 3'b111) && branch_taken;
    if (!m_running) begin
      if (start) begin
        m_running = 1'b1; m_done = 1'b0; m_pc = 0; m_cnt = 0;
        m_log.delete();
      end
    end else if (!stall) begin
      if (m_valid) begin
        m_log.push_back(m_addr);
        if (m_cnt < 65535) m_cnt++;
      end
      if (is_branch) begin
        m_pc = int'(branch_target);
        m_valid = 1'b0;
      end else if (m_pc == int'(prog_len)) begin
        m_valid = 1'b0; m_running = 1'b0; m_done = 1'b1;
      end else begin
        m_addr  = m_pc;
        m_instr = mem[m_pc];
        m_valid = 1'b1;
        m_pc    = (m_pc + 1) % MEMN;
      end
    end
  endtask

  always @(posedge clk) if (reset_n === 1'b1) model_step();
  always @(negedge reset_n) model_reset();

  function automatic int exp_cnt(input int c);
`ifdef FETCH_PERF_CNT_EN
    return c;
`else
    return 0 * c;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    chk("imem_addr", 32'(imem_addr), 32'(m_pc));
    chk("instr_valid", 32'(instr_valid), 32'(m_valid));
    chk("done", 32'(done), 32'(m_done));
    chk("retired_cnt", 32'(retired_cnt), 32'(exp_cnt(m_cnt)));
    if (m_valid) chk("instr", 32'(instr), 32'(m_instr));
  end

  task automatic check_log(input string name, input int e[$]);
    int bad;
    bad = -1;
    n_chk++;
    for (int i = 0; i < e.size() && i < m_log.size(); i++)
      if (bad < 0 && e[i] != m_log[i]) bad = i;
    if (e.size() != m_log.size() || bad >= 0) begin
      n_fail++;
      $display("FAIL %s: delivered %0d addrs (first diff idx %0d) expected %0d addrs",
               name, m_log.size(), bad, e.size());
    end
  endtask

  // ---------------- stimulus ----------------
  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int k;
    k = 0;
    while (done !== 1'b1 && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("done_reached", 32'(done), 32'd1);
  endtask

  int exp_q[$];
  int empty_q[$];

  initial begin
    reset_n = 1'b0; start = 1'b0; stall = 1'b0; branch_taken = 1'b0;
    prog_len = '0; branch_target = '0;
    for (int i = 0; i < int'(MEMN); i++) mem[i] = {3'(i % 7), 6'(i + 5)};
    mem[2] = 9'h1C0;  // BLQZ
    model_reset();

    repeat (2) @(negedge clk);
    chk("rst_addr", 32'(imem_addr), 32'd0);
    chk("rst_instr", 32'(instr), 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_cnt", 32'(retired_cnt), 32'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Straight line.
    prog_len = 10'd4;
    pulse_start();
    chk("s1_first_bubble", 32'(instr_valid), 32'd0);
    @(negedge clk);
    chk("s1_first_valid", 32'(instr_valid), 32'd1);
    chk("s1_first_instr", 32'(instr), 32'h005);
    wait_done(20);
    exp_q = '{0, 1, 2, 3};
    check_log("s1_log", exp_q);
`ifdef FETCH_PERF_CNT_EN
    chk("s1_cnt", 32'(retired_cnt), 32'd4);
`else
    chk("s1_cnt", 32'(retired_cnt), 32'd0);
`endif

    // Taken branch at address 2 -> 7.
    prog_len = 10'd10;
    pulse_start();
    repeat (3) @(negedge clk);
    chk("s2_blqz_in_decode", 32'(instr), 32'h1C0);
    branch_taken = 1'b1; branch_target = 10'd7;
    @(negedge clk);
    branch_taken = 1'b0;
    chk("s2_bubble", 32'(instr_valid), 32'd0);
    chk("s2_redirect", 32'(imem_addr), 32'd7);
    @(negedge clk);
    chk("s2_target_instr", 32'(instr), 32'h00C);
    wait_done(30);
    exp_q = '{0, 1, 2, 7, 8, 9};
    check_log("s2_log", exp_q);

    // branch_taken during a non-branch instruction is ignored.
    prog_len = 10'd5;
    pulse_start();
    repeat (2) @(negedge clk);
    branch_taken = 1'b1; branch_target = 10'd7;
    @(negedge clk);
    branch_taken = 1'b0;
    chk("s3_no_redirect", 32'(imem_addr), 32'd3);
    wait_done(30);
    exp_q = '{0, 1, 2, 3, 4};
    check_log("s3_log", exp_q);

    // Stall three cycles with mem[1] in decode.
    prog_len = 10'd4;
    pulse_start();
    repeat (2) @(negedge clk);
    stall = 1'b1;
    repeat (3) @(negedge clk);
    chk("s4_hold_addr", 32'(imem_addr), 32'd2);
    chk("s4_hold_instr", 32'(instr), 32'h046);
    chk("s4_hold_valid", 32'(instr_valid), 32'd1);
    stall = 1'b0;
    wait_done(30);
    exp_q = '{0, 1, 2, 3};
    check_log("s4_log", exp_q);
`ifdef FETCH_PERF_CNT_EN
    chk("s4_cnt", 32'(retired_cnt), 32'd4);
`else
    chk("s4_cnt", 32'(retired_cnt), 32'd0);
`endif

    // Empty program.
    prog_len = 10'd0;
    pulse_start();
    chk("s5_not_yet_done", 32'(done), 32'd0);
    @(negedge clk);
    chk("s5_done", 32'(done), 32'd1);
    chk("s5_no_valid", 32'(instr_valid), 32'd0);
    check_log("s5_log", empty_q);

    // Branch taken on the last instruction keeps the unit running.
    prog_len = 10'd3;
    pulse_start();
    repeat (3) @(negedge clk);
    branch_taken = 1'b1; branch_target = 10'd0;
    @(negedge clk);
    branch_taken = 1'b0;
    chk("s6_still_running", 32'(done), 32'd0);
    chk("s6_redirect", 32'(imem_addr), 32'd0);
    wait_done(30);
    exp_q = '{0, 1, 2, 0, 1, 2};
    check_log("s6_log", exp_q);

    // Asynchronous reset mid-run, then restart.
    prog_len = 10'd10;
    pulse_start();
    repeat (5) @(negedge clk);
    chk("s7_pc_before_reset", 32'(imem_addr), 32'd5);
    #2 reset_n = 1'b0;
    #1;
    chk("s7_rst_addr", 32'(imem_addr), 32'd0);
    chk("s7_rst_valid", 32'(instr_valid), 32'd0);
    chk("s7_rst_instr", 32'(instr), 32'd0);
    chk("s7_rst_done", 32'(done), 32'd0);
    chk("s7_rst_cnt", 32'(retired_cnt), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    pulse_start();
    wait_done(30);
    exp_q = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9};
    check_log("s7_log", exp_q);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage that sits directly upstream of the control decoder. It owns the program counter, drives the instruction-memory address, and registers the fetched 9-bit instruction; bits [8:6] are the 3-bit opcode consumed by the decoder. It resolves taken BLQZ branches from the datapath, supports stalls, and signals program completion with a start/done handshake.

## Interface
- PC_W, 10, program counter and instruction-memory address width
- IW, 9, instruction width; opcode is instr[IW-1:IW-3]
- BLQZ_OP, 3'b111, opcode value of the branch instruction
- clk  in  1  single system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse that begins execution at address 0
- prog_len  in  PC_W  address one past the last instruction; sampled every cycle
- imem_addr  out  PC_W  instruction-memory address, combinational copy of pc
- imem_rdata  in  IW  instruction-memory read data, combinational from imem_addr
- instr  out  IW  registered instruction presented to the decoder
- instr_valid  out  1  instr is a live, non-squashed instruction
- stall  in  1  hold pc, instr and instr_valid
- branch_taken  in  1  datapath condition true for the BLQZ currently in instr
- branch_target  in  PC_W  target address from the branch lookup table
- done  out  1  program finished, level until next start
- retired_cnt  out  16  count of valid instructions delivered (see Configuration)

## Operation
- States: IDLE, RUN, DONE.
- Reset: state=IDLE, pc=0, instr=0, instr_valid=0, done=0, retired_cnt=0. imem_addr therefore reads 0.
- IDLE: pc held at 0, instr_valid=0. On start, go to RUN with pc=0.
- RUN, stall=1: pc, instr, instr_valid and state all hold. branch_taken is ignored.
- RUN, stall=0, taken branch: the condition is instr_valid=1, instr opcode==BLQZ_OP, and branch_taken=1. Then pc<=branch_target and instr_valid<=0, so the wrong-path fetch is squashed. State stays RUN. The branch has priority over end-of-program detection.
- RUN, stall=0, pc==prog_len, no taken branch: instr_valid<=0 and the state goes to DONE. No fetch happens at prog_len.
- RUN, stall=0, otherwise: instr<=imem_rdata, instr_valid<=1, pc<=pc+1. pc wraps modulo 2^PC_W.
- branch_taken is ignored when instr_valid=0 or when the opcode is not BLQZ_OP.
- DONE: done=1 and instr_valid=0. On start, clear done, set pc=0 and go to RUN. start is ignored while in RUN.
- prog_len==0: start leads to RUN, then DONE on the next edge. No valid instruction is issued.
- Asserting reset_n low mid-program forces the reset values immediately (asynchronously). No instruction is delivered after reset.

## Timing
- Fetch latency: the instruction at address A appears on instr with instr_valid=1 one clock after the edge on which pc==A is used for a fetch.
- After start, the first valid instruction (address 0) appears on the second rising edge.
- Taken branch costs exactly one bubble cycle (instr_valid=0). The target instruction is valid two edges after the branch is in decode.
- done rises on the edge after the last fetch cycle. Once the last instruction's valid cycle completes, that instruction has left instr.
- stall is sampled every edge and takes effect with zero latency.

## Configuration
- FETCH_PERF_CNT_EN defined: retired_cnt increments on every edge where instr_valid=1 and stall=0. It saturates at 16'hFFFF and clears on start and on reset.
- FETCH_PERF_CNT_EN undefined: no counter logic is built and retired_cnt is tied to 0.

## Test plan
- Straight line: prog_len=4, pulse start → instr_valid high for 4 consecutive cycles carrying mem[0..3], then done=1 one cycle later. With the macro, retired_cnt=4.
- Taken branch: mem[2]=BLQZ, branch_taken=1 while it is in decode, branch_target=7 → one bubble, then mem[7]. mem[3] is never valid.
- Non-branch with branch_taken: branch_taken=1 during an ADD → ignored, sequential flow continues.
- Stall: stall=1 for 3 cycles while mem[1] is in decode → instr holds mem[1] with instr_valid=1, pc holds at 2, and the counter increments only once.
- End boundary: prog_len=0 → done=1 two edges after start with no valid instruction. A branch taken on the last instruction (prog_len=3, mem[2]=BLQZ, target 0) keeps the unit in RUN.
- Reset mid-run: reset_n low at pc=5 → outputs return to reset values immediately. A restart with start then refetches from address 0.
